// File: rtl/std_nbdcache_vldty_pkg.sv
// Shared types and helpers for the D-cache valid/dirty SRAM sequencer.
package std_nbdcache_vldty_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      SERVE = 2'd1,
      CLEAR = 2'd2
   } vldty_state_e;

   // Width of a port index; a single port still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/std_nbdcache_vldty_ctrl_if.sv
// Requester and SRAM-side bundle for the valid/dirty SRAM sequencer.
interface std_nbdcache_vldty_ctrl_if #(
   parameter int unsigned NumPorts  = 4,
   parameter int unsigned NumWords  = 256,
   parameter int unsigned DataWidth = 128,
   parameter int unsigned ByteWidth = 8
);
   localparam int unsigned AddrWidth = $clog2(NumWords);
   localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;

   logic [NumPorts-1:0]                 req_i;
   logic [NumPorts-1:0]                 gnt_o;
   logic [NumPorts-1:0]                 we_i;
   logic [NumPorts-1:0][AddrWidth-1:0]  addr_i;
   logic [NumPorts-1:0][DataWidth-1:0]  wdata_i;
   logic [NumPorts-1:0][BeWidth-1:0]    be_i;
   logic [NumPorts-1:0]                 rvalid_o;
   logic [DataWidth-1:0]                rdata_o;

   logic                                sram_req_o;
   logic                                sram_we_o;
   logic [AddrWidth-1:0]                sram_addr_o;
   logic [DataWidth-1:0]                sram_wdata_o;
   logic [BeWidth-1:0]                  sram_be_o;
   logic [DataWidth-1:0]                sram_rdata_i;

   // master: requesters plus the SRAM macro; slave: the sequencer
   modport master (
      output req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
      input  gnt_o, rvalid_o, rdata_o,
      input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
      output gnt_o, rvalid_o, rdata_o,
      output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
   );

endinterface

// File: rtl/std_nbdcache_vldty_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module std_nbdcache_vldty_rr_arb
   import std_nbdcache_vldty_pkg::*;
#(
   parameter  int unsigned NumPorts = 4,
   localparam int unsigned IdxWidth = idx_width(NumPorts)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en,
   input  logic [NumPorts-1:0] req,
   output logic [NumPorts-1:0] gnt_c,
   output logic [IdxWidth-1:0] gnt_idx_c,
   output logic                gnt_valid_c
);

   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumPorts - 1);

   logic [IdxWidth-1:0] ptr_q;
   logic [IdxWidth-1:0] cand_idx;
   int unsigned         cand;

   // First asserted request at or after the pointer, wrapping around.
   always_comb begin
      gnt_c       = '0;
      gnt_idx_c   = '0;
      gnt_valid_c = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         cand     = (32'(ptr_q) + i) % NumPorts;
         cand_idx = IdxWidth'(cand);
         if (en && !gnt_valid_c && req[cand_idx]) begin
            gnt_c[cand_idx] = 1'b1;
            gnt_idx_c       = cand_idx;
            gnt_valid_c     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (gnt_valid_c) begin
         ptr_q <= (gnt_idx_c == LastIdx) ? '0 : gnt_idx_c + IdxWidth'(1);
      end
   end

endmodule

// File: rtl/std_nbdcache_vldty_ctrl.sv
// Valid/dirty SRAM sequencer: zero sweep after reset and on clear, round-robin access otherwise.
module std_nbdcache_vldty_ctrl
   import std_nbdcache_vldty_pkg::*;
#(
   parameter  int unsigned NumPorts  = 4,
   parameter  int unsigned NumWords  = 256,
   parameter  int unsigned DataWidth = 128,
   parameter  int unsigned ByteWidth = 8,
   localparam int unsigned AddrWidth = $clog2(NumWords),
   localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
   localparam int unsigned IdxWidth  = idx_width(NumPorts)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clear_i,
   output logic                        busy_o,
   std_nbdcache_vldty_ctrl_if.slave    bus
);

   localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

   vldty_state_e         state_q;
   logic [AddrWidth-1:0] cnt_q;
   logic                 busy_q;
   logic [NumPorts-1:0]  rvalid_q;

   logic                 arb_en_c;
   logic                 sweep_c;
   logic [NumPorts-1:0]  gnt_c;
   logic [IdxWidth-1:0]  gnt_idx_c;
   logic                 gnt_valid_c;

   assign arb_en_c = (state_q == SERVE);
   // Sweep writes are held off while reset is asserted so the strobe reads idle.
   assign sweep_c  = (state_q != SERVE) && !rst_i;

   std_nbdcache_vldty_rr_arb #(
      .NumPorts (NumPorts)
   ) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en          (arb_en_c),
      .req         (bus.req_i),
      .gnt_c       (gnt_c),
      .gnt_idx_c   (gnt_idx_c),
      .gnt_valid_c (gnt_valid_c)
   );

   // Sequencer state, sweep counter and read-return tracking.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= INIT;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
         rvalid_q <= '0;
      end else begin
         rvalid_q <= (gnt_valid_c && !bus.we_i[gnt_idx_c]) ? gnt_c : '0;
         case (state_q)
            INIT, CLEAR: begin
               cnt_q <= cnt_q + AddrWidth'(1);
               if (cnt_q == LastAddr) begin
                  state_q <= SERVE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            SERVE: begin
               // The grant of the clear cycle itself is still honoured above.
               if (clear_i) begin
                  state_q <= CLEAR;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= INIT;
               busy_q  <= 1'b1;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // SRAM port mux: zero sweep or the granted requester.
   always_comb begin
      bus.sram_req_o   = 1'b0;
      bus.sram_we_o    = 1'b0;
      bus.sram_addr_o  = '0;
      bus.sram_wdata_o = '0;
      bus.sram_be_o    = '0;
      if (sweep_c) begin
         bus.sram_req_o   = 1'b1;
         bus.sram_we_o    = 1'b1;
         bus.sram_addr_o  = cnt_q;
         bus.sram_be_o    = '1;
      end else if (gnt_valid_c) begin
         bus.sram_req_o   = 1'b1;
         bus.sram_we_o    = bus.we_i[gnt_idx_c];
         bus.sram_addr_o  = bus.addr_i[gnt_idx_c];
         bus.sram_wdata_o = bus.wdata_i[gnt_idx_c];
         bus.sram_be_o    = bus.be_i[gnt_idx_c];
      end
   end

   assign bus.gnt_o    = gnt_c;
   assign bus.rvalid_o = rvalid_q;
   assign bus.rdata_o  = bus.sram_rdata_i;
   assign busy_o       = busy_q;

endmodule
